ysyx_25030093_sram_slave: RTL and testbench

//  Responder (slave) end of the LSU<->SRAM load/store handshake.

---
 rtl/ysyx_25030093_sram_pkg.sv | 37 +++
 rtl/ysyx_25030093_sram_array.sv | 31 +++
 rtl/ysyx_25030093_sram_slave.sv | 170 +++++++++++++++++
 tb/tb_ysyx_25030093_sram_slave.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030093_sram_pkg.sv
// Shared definitions for the LSU-facing SRAM responder: store size codes, FSM states, captured write beat.
// Pure declarations, no latency; no flow control lives here.
// Used by both FSMs and the lane/mask logic in the top level.
package ysyx_25030093_sram_pkg;

    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef struct packed {
        logic [2:0]  size;
        logic [31:0] data;
    } wbeat_t;

    // Byte-enable pattern for a lane-0 access; unknown size codes write nothing.
    function automatic logic [3:0] size_mask(input logic [2:0] sz);
        case (sz)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25030093_sram_array.sv
// Word-organised storage: one combinational read port, one byte-enabled synchronous write port.
// Latency: read 0 cycles, write lands on the next clk edge; contents are never reset.
// Backpressure: none, always ready.
module ysyx_25030093_sram_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [3:0]        wbe,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Combinational read sees the pre-edge contents, giving read-before-write on a shared edge.
    assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_25030093_sram_slave.sv
// LSU<->SRAM responder: independent read (ar/r) and write (aw/w/b) FSMs around a word array.
// Latency: rvalid RD_LAT edges after ar accept, bvalid WR_LAT edges after both aw and w are held.
// Backpressure: rvalid/bvalid held until rready/bready; no new ar or aw/w accepted until then.
module ysyx_25030093_sram_slave
    import ysyx_25030093_sram_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] LSU_SRAM_araddr,
    input  logic        LSU_SRAM_arvalid,
    output logic        SRAM_LSU_arready,
    output logic [31:0] SRAM_LSU_rdata,
    output logic        SRAM_LSU_rvalid,
    input  logic        LSU_SRAM_rready,
    input  logic [31:0] LSU_SRAM_awaddr,
    input  logic        LSU_SRAM_awvalid,
    output logic        SRAM_LSU_awready,
    input  logic [31:0] LSU_SRAM_wdata,
    input  logic [2:0]  LSU_SRAM_wstrb,
    input  logic        LSU_SRAM_wvalid,
    output logic        SRAM_LSU_wready,
    output logic        SRAM_LSU_bvalid,
    input  logic        LSU_SRAM_bready
);

    localparam int RC_W = $clog2(RD_LAT + 1);
    localparam int WC_W = $clog2(WR_LAT + 1);

    r_state_t          r_state, r_state_nxt;
    logic [RC_W-1:0]   rd_cnt;
    logic [ADDR_W+1:0] rd_addr;
    logic              rd_commit;
    logic [31:0]       arr_rdata;
    logic [31:0]       rd_shifted;

    w_state_t          w_state, w_state_nxt;
    logic [WC_W-1:0]   wr_cnt;
    logic [ADDR_W+1:0] wr_addr;
    wbeat_t            wr_beat;
    logic              aw_got, w_got;
    logic              aw_fire, w_fire;
    logic              aw_have, w_have;
    logic              wr_commit;
    logic [63:0]       st_wide_dat;
    logic [7:0]        st_wide_be;

    logic              unused_bits;

    // ---------------- read path ----------------
    assign SRAM_LSU_arready = (r_state == R_IDLE);
    assign SRAM_LSU_rvalid  = (r_state == R_RESP);
    assign rd_shifted       = arr_rdata >> {rd_addr[1:0], 3'b000};

    always_comb begin
        r_state_nxt = r_state;
        rd_commit   = 1'b0;
        case (r_state)
            R_IDLE: if (LSU_SRAM_arvalid) r_state_nxt = R_WAIT;
            R_WAIT: begin
                if (rd_cnt == '0) begin
                    r_state_nxt = R_RESP;
                    rd_commit   = 1'b1;
                end
            end
            R_RESP: if (LSU_SRAM_rready) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= R_IDLE;
            rd_cnt         <= '0;
            rd_addr        <= '0;
            SRAM_LSU_rdata <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (r_state == R_IDLE && LSU_SRAM_arvalid) begin
                rd_addr <= LSU_SRAM_araddr[ADDR_W+1:0];
                rd_cnt  <= RC_W'(RD_LAT - 1);
            end else if (r_state == R_WAIT && rd_cnt != '0) begin
                rd_cnt <= rd_cnt - RC_W'(1);
            end
            if (rd_commit) begin
                SRAM_LSU_rdata <= rd_shifted;
            end
        end
    end

    // ---------------- write path ----------------
    assign SRAM_LSU_awready = (w_state == W_IDLE) && !aw_got;
    assign SRAM_LSU_wready  = (w_state == W_IDLE) && !w_got;
    assign SRAM_LSU_bvalid  = (w_state == W_RESP);
    assign aw_fire          = LSU_SRAM_awvalid && SRAM_LSU_awready;
    assign w_fire           = LSU_SRAM_wvalid && SRAM_LSU_wready;
    assign aw_have          = aw_got || aw_fire;
    assign w_have           = w_got || w_fire;

    always_comb begin
        w_state_nxt = w_state;
        wr_commit   = 1'b0;
        case (w_state)
            W_IDLE: if (aw_have && w_have) w_state_nxt = W_WAIT;
            W_WAIT: begin
                if (wr_cnt == '0) begin
                    w_state_nxt = W_RESP;
                    wr_commit   = 1'b1;
                end
            end
            W_RESP: if (LSU_SRAM_bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            wr_cnt  <= '0;
            wr_addr <= '0;
            wr_beat <= '0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_fire) begin
                wr_addr <= LSU_SRAM_awaddr[ADDR_W+1:0];
            end
            if (w_fire) begin
                wr_beat.size <= LSU_SRAM_wstrb;
                wr_beat.data <= LSU_SRAM_wdata;
            end
            if (w_state == W_IDLE) begin
                if (aw_have && w_have) begin
                    aw_got <= 1'b0;
                    w_got  <= 1'b0;
                    wr_cnt <= WC_W'(WR_LAT - 1);
                end else begin
                    if (aw_fire) aw_got <= 1'b1;
                    if (w_fire)  w_got  <= 1'b1;
                end
            end else if (w_state == W_WAIT && wr_cnt != '0) begin
                wr_cnt <= wr_cnt - WC_W'(1);
            end
        end
    end

    // Shifting into a double-width vector and keeping the low half drops lanes past byte 3.
    assign st_wide_dat = {32'b0, wr_beat.data} << {wr_addr[1:0], 3'b000};
    assign st_wide_be  = {4'b0, size_mask(wr_beat.size)} << wr_addr[1:0];

    ysyx_25030093_sram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (wr_commit),
        .waddr (wr_addr[ADDR_W+1:2]),
        .wbe   (st_wide_be[3:0]),
        .wdata (st_wide_dat[31:0]),
        .raddr (rd_addr[ADDR_W+1:2]),
        .rdata (arr_rdata)
    );

    assign unused_bits = ^{LSU_SRAM_araddr[31:ADDR_W+2], LSU_SRAM_awaddr[31:ADDR_W+2],
                           st_wide_dat[63:32], st_wide_be[7:4]};

endmodule

// File: tb/tb_ysyx_25030093_sram_slave.sv
// Directed bench for the SRAM responder: latency, lane handling, backpressure, collisions, async reset.
module tb_ysyx_25030093_sram_slave;

    logic        clk;
    logic        rst_n;
    logic [31:0] LSU_SRAM_araddr;
    logic        LSU_SRAM_arvalid;
    logic        SRAM_LSU_arready;
    logic [31:0] SRAM_LSU_rdata;
    logic        SRAM_LSU_rvalid;
    logic        LSU_SRAM_rready;
    logic [31:0] LSU_SRAM_awaddr;
    logic        LSU_SRAM_awvalid;
    logic        SRAM_LSU_awready;
    logic [31:0] LSU_SRAM_wdata;
    logic [2:0]  LSU_SRAM_wstrb;
    logic        LSU_SRAM_wvalid;
    logic        SRAM_LSU_wready;
    logic        SRAM_LSU_bvalid;
    logic        LSU_SRAM_bready;

    int errors = 0;
    int checks = 0;

    ysyx_25030093_sram_slave #(
        .ADDR_W (10),
        .RD_LAT (2),
        .WR_LAT (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .LSU_SRAM_araddr  (LSU_SRAM_araddr),
        .LSU_SRAM_arvalid (LSU_SRAM_arvalid),
        .SRAM_LSU_arready (SRAM_LSU_arready),
        .SRAM_LSU_rdata   (SRAM_LSU_rdata),
        .SRAM_LSU_rvalid  (SRAM_LSU_rvalid),
        .LSU_SRAM_rready  (LSU_SRAM_rready),
        .LSU_SRAM_awaddr  (LSU_SRAM_awaddr),
        .LSU_SRAM_awvalid (LSU_SRAM_awvalid),
        .SRAM_LSU_awready (SRAM_LSU_awready),
        .LSU_SRAM_wdata   (LSU_SRAM_wdata),
        .LSU_SRAM_wstrb   (LSU_SRAM_wstrb),
        .LSU_SRAM_wvalid  (LSU_SRAM_wvalid),
        .SRAM_LSU_wready  (SRAM_LSU_wready),
        .SRAM_LSU_bvalid  (SRAM_LSU_bvalid),
        .LSU_SRAM_bready  (LSU_SRAM_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach summary (time %0t, required end before 500000)", $time);
        $fatal(1, "watchdog expired");
    end

    // Issue aw+w together from a negedge; lat = posedges from accept to bvalid (64 = timed out).
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] sz, output int lat);
        lat = 0;
        LSU_SRAM_awaddr  = addr;
        LSU_SRAM_awvalid = 1'b1;
        LSU_SRAM_wdata   = data;
        LSU_SRAM_wstrb   = sz;
        LSU_SRAM_wvalid  = 1'b1;
        @(negedge clk);
        LSU_SRAM_awvalid = 1'b0;
        LSU_SRAM_wvalid  = 1'b0;
        while (!SRAM_LSU_bvalid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        LSU_SRAM_bready = 1'b1;
        @(negedge clk);
        LSU_SRAM_bready = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
        lat = 0;
        LSU_SRAM_araddr  = addr;
        LSU_SRAM_arvalid = 1'b1;
        @(negedge clk);
        LSU_SRAM_arvalid = 1'b0;
        while (!SRAM_LSU_rvalid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        data = SRAM_LSU_rdata;
        LSU_SRAM_rready = 1'b1;
        @(negedge clk);
        LSU_SRAM_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        LSU_SRAM_araddr = '0; LSU_SRAM_arvalid = 1'b0; LSU_SRAM_rready = 1'b0;
        LSU_SRAM_awaddr = '0; LSU_SRAM_awvalid = 1'b0;
        LSU_SRAM_wdata = '0; LSU_SRAM_wstrb = '0; LSU_SRAM_wvalid = 1'b0; LSU_SRAM_bready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (SRAM_LSU_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", SRAM_LSU_rvalid); end
        checks++; if (SRAM_LSU_bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid: got %b want 0", SRAM_LSU_bvalid); end
        checks++; if (SRAM_LSU_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", SRAM_LSU_rdata); end
        checks++; if (SRAM_LSU_arready !== 1'b1) begin errors++; $display("FAIL reset_arready: got %b want 1", SRAM_LSU_arready); end
        checks++; if (SRAM_LSU_awready !== 1'b1) begin errors++; $display("FAIL reset_awready: got %b want 1", SRAM_LSU_awready); end
        checks++; if (SRAM_LSU_wready !== 1'b1) begin errors++; $display("FAIL reset_wready: got %b want 1", SRAM_LSU_wready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_rw();
        int lat;
        logic [31:0] d;
        bus_write(32'h10, 32'hDEADBEEF, 3'd4, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
        bus_read(32'h10, d, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", d); end
    endtask

    task automatic test_lanes();
        int lat;
        logic [31:0] d;
        bus_write(32'h11, 32'h000000AA, 3'd1, lat);
        bus_read(32'h10, d, lat);
        checks++; if (d !== 32'hDEADAAEF) begin errors++; $display("FAIL sb_word: got %h want deadaaef", d); end
        bus_read(32'h11, d, lat);
        checks++; if (d[7:0] !== 8'hAA) begin errors++; $display("FAIL lbu_11: got %h want aa", d[7:0]); end
        checks++; if (d !== 32'h00DEADAA) begin errors++; $display("FAIL misaligned_11: got %h want 00deadaa", d); end
        bus_write(32'h12, 32'hFFFF1234, 3'd2, lat);
        bus_read(32'h10, d, lat);
        checks++; if (d !== 32'h1234AAEF) begin errors++; $display("FAIL sh_word: got %h want 1234aaef", d); end
        bus_read(32'h12, d, lat);
        checks++; if (d !== 32'h00001234) begin errors++; $display("FAIL lhu_12: got %h want 00001234", d); end
        // Half store at lane 3 must touch byte 3 only and never the next word.
        bus_write(32'h14, 32'h00000000, 3'd4, lat);
        bus_write(32'h13, 32'h00005678, 3'd2, lat);
        bus_read(32'h10, d, lat);
        checks++; if (d !== 32'h7834AAEF) begin errors++; $display("FAIL sh_lane3: got %h want 7834aaef", d); end
        bus_read(32'h14, d, lat);
        checks++; if (d !== 32'h00000000) begin errors++; $display("FAIL no_cross_word: got %h want 00000000", d); end
        bus_read(32'h13, d, lat);
        checks++; if (d !== 32'h00000078) begin errors++; $display("FAIL lbu_13: got %h want 00000078", d); end
        bus_write(32'h10, 32'hFFFFFFFF, 3'd3, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL illegal_bvalid: got lat %0d want 2", lat); end
        bus_read(32'h10, d, lat);
        checks++; if (d !== 32'h7834AAEF) begin errors++; $display("FAIL illegal_nowrite: got %h want 7834aaef", d); end
        bus_read(32'h1010, d, lat);
        checks++; if (d !== 32'h7834AAEF) begin errors++; $display("FAIL addr_wrap: got %h want 7834aaef", d); end
    endtask

    task automatic test_split_write();
        int lat;
        logic [31:0] d;
        LSU_SRAM_awaddr  = 32'h30;
        LSU_SRAM_awvalid = 1'b1;
        @(negedge clk);
        LSU_SRAM_awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (SRAM_LSU_awready !== 1'b0) begin errors++; $display("FAIL split_awready[%0d]: got %b want 0", i, SRAM_LSU_awready); end
            checks++; if (SRAM_LSU_wready !== 1'b1) begin errors++; $display("FAIL split_wready[%0d]: got %b want 1", i, SRAM_LSU_wready); end
            if (i < 2) @(negedge clk);
        end
        LSU_SRAM_wdata  = 32'hCAFEF00D;
        LSU_SRAM_wstrb  = 3'd4;
        LSU_SRAM_wvalid = 1'b1;
        @(negedge clk);
        LSU_SRAM_wvalid = 1'b0;
        checks++; if (SRAM_LSU_wready !== 1'b0) begin errors++; $display("FAIL split_wready_low: got %b want 0", SRAM_LSU_wready); end
        lat = 0;
        while (!SRAM_LSU_bvalid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL split_b_latency: got %0d want 2", lat); end
        LSU_SRAM_bready = 1'b1;
        @(negedge clk);
        LSU_SRAM_bready = 1'b0;
        checks++; if (SRAM_LSU_awready !== 1'b1 || SRAM_LSU_bvalid !== 1'b0) begin
            errors++; $display("FAIL split_back_idle: got awready=%b bvalid=%b want 1/0", SRAM_LSU_awready, SRAM_LSU_bvalid);
        end
        bus_read(32'h30, d, lat);
        checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL split_data: got %h want cafef00d", d); end
    endtask

    task automatic test_backpressure();
        int lat;
        bus_write(32'h40, 32'h11223344, 3'd4, lat);
        LSU_SRAM_araddr  = 32'h40;
        LSU_SRAM_arvalid = 1'b1;
        @(negedge clk);
        LSU_SRAM_arvalid = 1'b0;
        lat = 0;
        while (!SRAM_LSU_rvalid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (SRAM_LSU_rvalid !== 1'b1 || SRAM_LSU_rdata !== 32'h11223344 || SRAM_LSU_arready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got rvalid=%b rdata=%h arready=%b want 1/11223344/0",
                         i, SRAM_LSU_rvalid, SRAM_LSU_rdata, SRAM_LSU_arready);
            end
            @(negedge clk);
        end
        LSU_SRAM_rready = 1'b1;
        @(negedge clk);
        LSU_SRAM_rready = 1'b0;
        checks++; if (SRAM_LSU_rvalid !== 1'b0 || SRAM_LSU_arready !== 1'b1) begin
            errors++; $display("FAIL release: got rvalid=%b arready=%b want 0/1", SRAM_LSU_rvalid, SRAM_LSU_arready);
        end
    endtask

    task automatic test_same_cycle();
        int lat;
        logic [31:0] d;
        bus_write(32'h20, 32'hAAAA5555, 3'd4, lat);
        LSU_SRAM_araddr  = 32'h20;
        LSU_SRAM_arvalid = 1'b1;
        LSU_SRAM_awaddr  = 32'h20;
        LSU_SRAM_awvalid = 1'b1;
        LSU_SRAM_wdata   = 32'h12345678;
        LSU_SRAM_wstrb   = 3'd4;
        LSU_SRAM_wvalid  = 1'b1;
        @(negedge clk);
        LSU_SRAM_arvalid = 1'b0;
        LSU_SRAM_awvalid = 1'b0;
        LSU_SRAM_wvalid  = 1'b0;
        lat = 0;
        while (!SRAM_LSU_rvalid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (SRAM_LSU_bvalid !== 1'b1 || lat !== 2) begin
            errors++; $display("FAIL collide_timing: got bvalid=%b lat=%0d want 1/2", SRAM_LSU_bvalid, lat);
        end
        checks++; if (SRAM_LSU_rdata !== 32'hAAAA5555) begin errors++; $display("FAIL collide_old: got %h want aaaa5555", SRAM_LSU_rdata); end
        LSU_SRAM_rready = 1'b1;
        LSU_SRAM_bready = 1'b1;
        @(negedge clk);
        LSU_SRAM_rready = 1'b0;
        LSU_SRAM_bready = 1'b0;
        bus_read(32'h20, d, lat);
        checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL collide_new: got %h want 12345678", d); end
    endtask

    task automatic test_reset_midread();
        int lat;
        logic [31:0] d;
        bus_write(32'h50, 32'h0BADF00D, 3'd4, lat);
        // Reset during R_RESP must clear rvalid without waiting for a clock edge.
        bus_read(32'h50, d, lat);
        LSU_SRAM_araddr  = 32'h50;
        LSU_SRAM_arvalid = 1'b1;
        @(negedge clk);
        LSU_SRAM_arvalid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (SRAM_LSU_rvalid !== 1'b1) begin errors++; $display("FAIL pre_reset_rvalid: got %b want 1", SRAM_LSU_rvalid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (SRAM_LSU_rvalid !== 1'b0 || SRAM_LSU_arready !== 1'b1 || SRAM_LSU_rdata !== 32'h0) begin
            errors++; $display("FAIL async_resp: got rvalid=%b arready=%b rdata=%h want 0/1/0", SRAM_LSU_rvalid, SRAM_LSU_arready, SRAM_LSU_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Reset while the read is still counting down in R_WAIT.
        LSU_SRAM_araddr  = 32'h50;
        LSU_SRAM_arvalid = 1'b1;
        @(negedge clk);
        LSU_SRAM_arvalid = 1'b0;
        checks++; if (SRAM_LSU_arready !== 1'b0) begin errors++; $display("FAIL wait_arready: got %b want 0", SRAM_LSU_arready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (SRAM_LSU_rvalid !== 1'b0 || SRAM_LSU_arready !== 1'b1) begin
            errors++; $display("FAIL async_wait: got rvalid=%b arready=%b want 0/1", SRAM_LSU_rvalid, SRAM_LSU_arready);
        end
        repeat (2) @(negedge clk);
        checks++; if (SRAM_LSU_rvalid !== 1'b0) begin errors++; $display("FAIL dropped_read: got rvalid=%b want 0", SRAM_LSU_rvalid); end
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(32'h50, d, lat);
        checks++; if (d !== 32'h0BADF00D) begin errors++; $display("FAIL mem_kept_50: got %h want 0badf00d", d); end
        bus_read(32'h10, d, lat);
        checks++; if (d !== 32'h7834AAEF) begin errors++; $display("FAIL mem_kept_10: got %h want 7834aaef", d); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_lanes();
        test_split_write();
        test_backpressure();
        test_same_cycle();
        test_reset_midread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
